// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (128-bit reads) and LSU (32-bit ld/st); one transaction in flight.
// Ready->rvalid is 3 cycles minimum (2 when rvalid rides with gnt); mem_gnt low holds the request and keeps both readies at 0.
module mem_port_arbiter #(
    parameter int LSU_MAX_STREAK = 4,
    parameter int STREAK_W       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_ready,
    output logic          if_rvalid,
    output logic [127:0]  if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [31:0]   ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic          ls_ready,
    output logic          ls_rvalid,
    output logic [31:0]   ls_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_wide,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [127:0]  mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LSU_MAX_STREAK);

    state_t              state_q;
    logic                owner_ls_q;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                mem_req_q;
    logic                mem_we_q;
    logic                mem_wide_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                if_rvalid_q;
    logic                ls_rvalid_q;
    logic [127:0]        if_rdata_q;
    logic [31:0]         ls_rdata_q;

    logic grant_if;
    logic grant_ls;
    logic fetch_forced;
    logic resp_take;
    logic if_addr_unused;

    // Fetch bundles are 16-byte aligned, so the low PC bits never reach memory.
    assign if_addr_unused = ^if_addr[3:0];

    assign fetch_forced = if_req && (streak_q == STREAK_MAX);
    assign grant_ls     = (state_q == IDLE) && ls_req && !fetch_forced;
    assign grant_if     = (state_q == IDLE) && if_req && !grant_ls;
    assign resp_take    = mem_rvalid && (((state_q == REQ) && mem_gnt) || (state_q == WAIT));

    always_comb begin
        streak_d = streak_q;
        if (grant_ls && if_req) begin
            if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end else if (grant_if || grant_ls) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_ls_q  <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wide_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_if || grant_ls) begin
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                        owner_ls_q <= grant_ls;
                        streak_q   <= streak_d;
                        if (grant_ls) begin
                            mem_addr_q  <= ls_addr;
                            mem_we_q    <= ls_we;
                            mem_wide_q  <= 1'b0;
                            mem_wdata_q <= ls_wdata;
                        end else begin
                            mem_addr_q  <= {if_addr[31:4], 4'b0};
                            mem_we_q    <= 1'b0;
                            mem_wide_q  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_rvalid ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // A store ack pulses ls_rvalid but leaves the last load data intact.
            if (resp_take) begin
                if (owner_ls_q) begin
                    ls_rvalid_q <= 1'b1;
                    if (!mem_we_q) begin
                        ls_rdata_q <= mem_rdata[31:0];
                    end
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= mem_rdata;
                end
            end
        end
    end

    assign if_ready  = grant_if;
    assign ls_ready  = grant_ls;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_wide  = mem_wide_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         if_req, ls_req, ls_we;
    logic [31:0]  if_addr, ls_addr, ls_wdata;
    logic         if_ready, if_rvalid, ls_ready, ls_rvalid;
    logic [127:0] if_rdata;
    logic [31:0]  ls_rdata;
    logic         mem_req, mem_we, mem_wide, busy;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_gnt, mem_rvalid;
    logic [127:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.LSU_MAX_STREAK(MAXS), .STREAK_W(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wide(mem_wide),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one job in flight, a delivery cycle after the response.
    bit           m_active, m_acc, m_deliver, m_own_ls, m_we, m_wide;
    logic [31:0]  m_addr, m_wdata, m_lsd;
    logic [127:0] m_ifd;
    int           m_streak;

    function automatic bit lsu_wins();
        return ls_req && !(if_req && m_streak == MAXS);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_acc = 0; m_deliver = 0; m_own_ls = 0; m_we = 0; m_wide = 0;
            m_addr = '0; m_wdata = '0; m_lsd = '0; m_ifd = '0; m_streak = 0;
        end else if (m_deliver) begin
            m_deliver = 0;
        end else if (!m_active) begin
            if (lsu_wins()) begin
                m_active = 1; m_acc = 0; m_own_ls = 1;
                m_we = ls_we; m_wide = 0; m_addr = ls_addr; m_wdata = ls_wdata;
                m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (if_req) begin
                m_active = 1; m_acc = 0; m_own_ls = 0;
                m_we = 0; m_wide = 1; m_addr = if_addr & 32'hFFFF_FFF0;
                m_streak = 0;
            end
        end else if ((m_acc || mem_gnt) && mem_rvalid) begin
            if (!m_own_ls) m_ifd = mem_rdata;
            else if (!m_we) m_lsd = mem_rdata[31:0];
            m_active = 0;
            m_deliver = 1;
        end else if (mem_gnt) begin
            m_acc = 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("busy",      busy,      m_active || m_deliver);
            chk("ls_ready",  ls_ready,  !(m_active || m_deliver) && lsu_wins());
            chk("if_ready",  if_ready,  !(m_active || m_deliver) && !lsu_wins() && if_req);
            chk("mem_req",   mem_req,   m_active && !m_acc);
            chk("mem_we",    mem_we,    m_we);
            chk("mem_wide",  mem_wide,  m_wide);
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("if_rvalid", if_rvalid, m_deliver && !m_own_ls);
            chk("ls_rvalid", ls_rvalid, m_deliver && m_own_ls);
            chk("if_rdata",  if_rdata,  m_ifd);
            chk("ls_rdata",  ls_rdata,  m_lsd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for any ready, check the winner, and return positioned in the REQ cycle.
    task automatic grab(input bit want_ls, input bit drop, output int t);
        bit got = 0;
        t = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (ls_ready || if_ready) begin
                got = 1;
                t = cyc;
                chk("grant_owner_ls", ls_ready, want_ls);
            end
        end
        if (!got) chk("grant_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        if (drop) begin
            if (want_ls) ls_req = 0;
            else         if_req = 0;
        end
    endtask

    // Grant after gdly idle REQ cycles; rvalid rdly cycles after grant (0 = same cycle). Ends in RESP.
    task automatic serve(input int gdly, input int rdly, input logic [127:0] rd);
        repeat (gdly) step();
        mem_gnt = 1;
        if (rdly == 0) begin
            mem_rvalid = 1;
            mem_rdata  = rd;
        end
        step();
        mem_gnt = 0;
        mem_rvalid = 0;
        if (rdly > 0) begin
            repeat (rdly - 1) step();
            mem_rvalid = 1;
            mem_rdata  = rd;
            step();
            mem_rvalid = 0;
        end
    endtask

    bit exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        int t;
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        rst = 1;
        step();

        // Lone fetch
        if_req = 1; if_addr = 32'h0000_0014;
        grab(0, 1, t);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_wide", mem_wide, 1);
        serve(0, 2, {32{4'hA}});
        chk("t1_lat", cyc - t, 4);
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_ls_rvalid", ls_rvalid, 0);
        chk("t1_if_rdata", if_rdata, {32{4'hA}});
        step();
        chk("t1_pulse_end", if_rvalid, 0);

        // Store then load
        ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
        grab(1, 1, t);
        chk("t2_we", mem_we, 1);
        chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        serve(0, 1, 128'h1234_5678_9ABC);
        chk("t2_st_ack", ls_rvalid, 1);
        chk("t2_st_keep", ls_rdata, 0);
        step();
        ls_req = 1; ls_we = 0; ls_addr = 32'h100;
        grab(1, 1, t);
        serve(0, 1, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF});
        chk("t2_lat", cyc - t, 3);
        chk("t2_ld", ls_rdata, 32'hDEAD_BEEF);
        step();

        // Contention with both requests held
        if_req = 1; if_addr = 32'h200; ls_req = 1; ls_we = 0; ls_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            grab(exp_order[k], 0, t);
            serve(0, 1, 128'(k + 1));
            step();
        end
        if_req = 0; ls_req = 0;
        step();

        // Backpressure with fetch also pending
        ls_req = 1; ls_we = 1; ls_addr = 32'h44; ls_wdata = 32'h55AA_55AA; if_req = 1;
        grab(1, 1, t);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_req", mem_req, 1);
            chk("t4_addr", mem_addr, 32'h44);
            chk("t4_wdata", mem_wdata, 32'h55AA_55AA);
            chk("t4_ready", if_ready | ls_ready, 0);
            chk("t4_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        serve(0, 1, '0);
        step();
        grab(0, 1, t);
        serve(0, 1, 128'hBEEF);
        step();

        // Same-cycle gnt and rvalid
        if_req = 1; if_addr = 32'h2C;
        grab(0, 1, t);
        chk("t5_addr", mem_addr, 32'h20);
        serve(0, 0, {32{4'h5}});
        chk("t5_lat", cyc - t, 2);
        chk("t5_rvalid", if_rvalid, 1);
        step();
        chk("t5_pulse_end", if_rvalid, 0);

        // Reset in WAIT with the streak at its limit
        if_req = 1; if_addr = 32'h400; ls_req = 1; ls_we = 0; ls_addr = 32'h80;
        for (int k = 0; k < 3; k++) begin
            grab(1, 0, t);
            serve(0, 1, 128'(32'hCAFE_0000 + k));
            step();
        end
        grab(1, 0, t);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        step();
        rst = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_mem_req", mem_req, 0);
        chk("t6_ls_rdata", ls_rdata, 0);
        if_req = 0; ls_req = 0;
        step();
        rst = 1;
        mem_rvalid = 1; mem_rdata = 128'h7777;
        step();
        mem_rvalid = 0;
        chk("t6_no_ls_rvalid", ls_rvalid, 0);
        chk("t6_no_if_rvalid", if_rvalid, 0);
        chk("t6_idle", busy, 0);
        if_req = 1; ls_req = 1;
        grab(1, 1, t);
        if_req = 0;
        serve(0, 1, 128'h9);
        chk("t6_ld", ls_rdata, 32'h9);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single main-memory port between two requesters: instruction fetch (128-bit bundle reads) and LSU (32-bit loads and stores).
- Memory side is a req/gnt handshake with a variable-latency rvalid response. One transaction is outstanding at a time.
- Sits between instruction_fetch/lsu and main_memory, and replaces their direct port wiring once memory becomes multi-cycle.
- Drives a busy flag used by hazard detection to stall the pipeline.

Parameters:
- LSU_MAX_STREAK, 4: maximum consecutive LSU grants while fetch is pending; the next grant is forced to fetch.
- STREAK_W, 3: width of the streak counter; must hold LSU_MAX_STREAK.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  fetch PC.
- if_ready  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  128  instruction bundle.
- ls_req  in  1  LSU request; held with ls_we/ls_addr/ls_wdata until ls_ready.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  32  LSU byte address.
- ls_wdata  in  32  store data.
- ls_ready  out  1  LSU request accepted this cycle (combinational).
- ls_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- ls_rdata  out  32  load data.
- mem_req  out  1  memory request (registered).
- mem_we  out  1  write.
- mem_wide  out  1  128-bit read (fetch).
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  response / write ack.
- mem_rdata  in  128  response data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; streak counter = 0.
  - All registered outputs = 0: mem_req, mem_we, mem_wide, mem_addr, mem_wdata, if_rvalid, ls_rvalid, if_rdata, ls_rdata.
  - Reset mid-transaction abandons it; no rvalid is produced. A late mem_rvalid is ignored because it arrives in IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE arbitration (combinational; the winner's ready is 1 this cycle):
  - ls_req only -> LSU wins. if_req only -> fetch wins.
  - Both requesting: LSU wins unless streak == LSU_MAX_STREAK, in which case fetch wins.
  - On a grant, latch the request into the mem_* registers, record the owner, and go to REQ.
  - Fetch grant latches mem_addr = {if_addr[31:4],4'b0}, mem_wide=1, mem_we=0.
  - LSU grant latches mem_addr = ls_addr, mem_we = ls_we, mem_wide=0, and mem_wdata = ls_wdata.
- Streak counter:
  - LSU grant while if_req=1 -> +1, saturating at LSU_MAX_STREAK.
  - Fetch grant, or LSU grant while if_req=0 -> 0.
- REQ:
  - mem_req=1; all mem_* outputs held stable until mem_gnt.
  - mem_gnt=1 -> mem_req drops next cycle. Next state is RESP if mem_rvalid is also 1 this cycle, else WAIT.
- WAIT:
  - mem_rvalid=1 -> capture the response and go to RESP. No timeout; waits indefinitely.
- Response capture (on the mem_rvalid cycle):
  - Owner fetch: if_rdata <= mem_rdata.
  - Owner LSU load: ls_rdata <= mem_rdata[31:0].
  - Owner LSU store: ls_rdata unchanged.
- RESP (one cycle): the owner's rvalid=1, the other rvalid=0; next state IDLE.
- Latency and throughput:
  - Minimum request-to-rvalid is 3 cycles: ready at N, mem_gnt at N+1 with mem_rvalid at N+2 -> rvalid at N+3.
  - If the response arrives with the grant, rvalid is at N+2.
  - The next grant is no earlier than the cycle after RESP.
- Data persistence: if_rdata and ls_rdata keep their value until the next capture.
- busy = (state != IDLE); ready outputs are 0 in every state other than IDLE.
- mem_rvalid or mem_gnt in IDLE: ignored, no state change.

Test Plan:
1. Lone fetch: if_req=1, if_addr=0x0000_0014; mem_gnt at the next cycle, mem_rvalid 2 cycles later with rdata=0xA..A -> mem_addr=0x10, mem_wide=1, if_rvalid single pulse, if_rdata=0xA..A, ls_rvalid=0.
2. Store then load: ls_we=1, addr=0x100, wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, ls_rvalid pulse. Then a load of 0x100 with mem_rdata[31:0]=0xDEADBEEF -> ls_rdata=0xDEADBEEF.
3. Contention: if_req and ls_req both held continuously, LSU_MAX_STREAK=4 -> grant order LSU,LSU,LSU,LSU,FETCH,LSU...; streak returns to 0 after the fetch grant.
4. Backpressure: mem_gnt held low for 5 cycles -> mem_req, mem_addr and mem_wdata are constant throughout, ready stays 0, busy=1.
5. Same-cycle gnt+rvalid: mem_gnt=1 and mem_rvalid=1 in the first REQ cycle -> rvalid the next cycle, WAIT is skipped.
6. Reset mid-op: rst=0 in WAIT, then release; a later mem_rvalid=1 -> no rvalid pulse, state IDLE, streak=0, mem_req=0, and a new request is granted normally.
